fetch_sequencer: RTL

Control-side initiator for the program counter. Generates the per-step control strobes (pc_out, pc_count, pc_jump, pc_reset) plus the fetch strobes for the memory address register, RAM and instruction register. It is a T-state machine that fetches one instruction, decodes its opcode and, for jump-class opcodes, drives the PC load using the instruction operand. It sits in the control unit, between the instruction register and flags on one side and the PC, MAR, RAM and IR enables on the other.

---
 rtl/nsc8_pkg.sv | 52 +++++
 rtl/fetch_sequencer_if.sv | 36 +++
 rtl/fetch_sequencer_seq_decode.sv | 70 +++++++
 rtl/fetch_sequencer.sv | 76 +++++++
 4 files changed

// File: rtl/nsc8_pkg.sv
// -----------------------------------------------------------------------------
// nsc8_pkg
// Shared definitions for the NSC8 control unit: opcode constants, the fetch
// sequencer state encoding and the bit positions of the control word that the
// decoder produces and the top-level fans out to the PC/MAR/RAM/IR strobes.
// Optional build macro used by consumers of this package: SINGLE_STEP_EN.
// -----------------------------------------------------------------------------
package nsc8_pkg;

   // Opcodes (instr[7:4])
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   // State encoding
   localparam logic [2:0] ST_INIT = 3'd0;
   localparam logic [2:0] ST_T0   = 3'd1;
   localparam logic [2:0] ST_T1   = 3'd2;
   localparam logic [2:0] ST_T2   = 3'd3;
   localparam logic [2:0] ST_HALT = 3'd4;

   typedef enum logic [2:0] {
      S_INIT = ST_INIT,
      S_T0   = ST_T0,
      S_T1   = ST_T1,
      S_T2   = ST_T2,
      S_HALT = ST_HALT
   } state_t;

   // Control-word bit indices
   localparam int CW_PC_RESET = 0;
   localparam int CW_PC_OUT   = 1;
   localparam int CW_PC_COUNT = 2;
   localparam int CW_PC_JUMP  = 3;
   localparam int CW_MAR_IN   = 4;
   localparam int CW_RAM_OUT  = 5;
   localparam int CW_IR_IN    = 6;
   localparam int CW_IR_OUT   = 7;
   localparam int CW_HALTED   = 8;
   localparam int CW_W        = 9;

   typedef logic [CW_W-1:0] cw_t;

   // Strobes that write or update state somewhere; bus drivers and halted
   // are excluded because they only reflect the current state.
   localparam cw_t CW_WRITE_MASK = cw_t'((1 << CW_PC_RESET) | (1 << CW_PC_COUNT) |
                                         (1 << CW_PC_JUMP)  | (1 << CW_MAR_IN)   |
                                         (1 << CW_IR_IN));

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Groups the fetch sequencer's control-side signals.
//   instr, flag_carry, flag_zero : IR contents and registered ALU flags
//   pc_reset, pc_out, pc_count, pc_jump : program counter controls
//   mar_in, ram_out, ir_in, ir_out      : fetch path enables
//   halted, t_step                      : status
// master = the sequencer, slave = the datapath side receiving the strobes.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
   logic [7:0] instr;
   logic       flag_carry;
   logic       flag_zero;
   logic       pc_reset;
   logic       pc_out;
   logic       pc_count;
   logic       pc_jump;
   logic       mar_in;
   logic       ram_out;
   logic       ir_in;
   logic       ir_out;
   logic       halted;
   logic [1:0] t_step;

   modport master (
      input  instr, flag_carry, flag_zero,
      output pc_reset, pc_out, pc_count, pc_jump,
             mar_in, ram_out, ir_in, ir_out, halted, t_step
   );

   modport slave (
      output instr, flag_carry, flag_zero,
      input  pc_reset, pc_out, pc_count, pc_jump,
             mar_in, ram_out, ir_in, ir_out, halted, t_step
   );
endinterface

// File: rtl/fetch_sequencer_seq_decode.sv
// -----------------------------------------------------------------------------
// seq_decode
// Combinational map from (state, opcode, flags) to control word, next state
// and T-step number.
//   i_state      : current sequencer state
//   i_opcode     : instr[7:4], only meaningful in T2
//   i_flag_carry : carry flag, consulted for JC in T2
//   i_flag_zero  : zero flag, consulted for JZ in T2
//   o_cw         : control word (bit positions from nsc8_pkg)
//   o_next       : next state
//   o_t_step     : 0/1/2 in T0/T1/T2, 0 otherwise
// -----------------------------------------------------------------------------
module seq_decode
   import nsc8_pkg::*;
(
   input  state_t     i_state,
   input  logic [3:0] i_opcode,
   input  logic       i_flag_carry,
   input  logic       i_flag_zero,
   output cw_t        o_cw,
   output state_t     o_next,
   output logic [1:0] o_t_step
);

   logic w_take_jump;

   always_comb begin
      o_cw        = '0;
      o_next      = S_INIT;
      o_t_step    = 2'd0;
      w_take_jump = 1'b0;
      unique case (i_state)
         S_INIT: begin
            o_cw[CW_PC_RESET] = 1'b1;
            o_next            = S_T0;
         end
         S_T0: begin
            o_cw[CW_PC_OUT] = 1'b1;
            o_cw[CW_MAR_IN] = 1'b1;
            o_next          = S_T1;
         end
         S_T1: begin
            o_cw[CW_RAM_OUT]  = 1'b1;
            o_cw[CW_IR_IN]    = 1'b1;
            o_cw[CW_PC_COUNT] = 1'b1;
            o_next            = S_T2;
            o_t_step          = 2'd1;
         end
         S_T2: begin
            o_t_step = 2'd2;
            o_next   = (i_opcode == OP_HLT) ? S_HALT : S_T0;
            case (i_opcode)
               OP_JMP:  w_take_jump = 1'b1;
               OP_JC:   w_take_jump = i_flag_carry;
               OP_JZ:   w_take_jump = i_flag_zero;
               default: w_take_jump = 1'b0;
            endcase
            // A taken jump puts the operand on the bus and loads the PC from it.
            o_cw[CW_IR_OUT]  = w_take_jump;
            o_cw[CW_PC_JUMP] = w_take_jump;
         end
         S_HALT: begin
            o_cw[CW_HALTED] = 1'b1;
            o_next          = S_HALT;
         end
         default: o_next = S_INIT;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// T-state machine (INIT, T0, T1, T2, HALT) that fetches an instruction,
// decodes its opcode and drives the PC load for taken jumps.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   step_en    : (SINGLE_STEP_EN builds only) advance enable
//   bus        : fetch_sequencer_if.master carrying instr/flags in and all
//                control strobes plus halted/t_step out
// Build macro: SINGLE_STEP_EN adds step_en; while it is low the state holds
// and the write strobes are suppressed, bus drivers follow the held state.
// -----------------------------------------------------------------------------
module fetch_sequencer
   import nsc8_pkg::*;
#(
   parameter int N    = 4,
   parameter int OP_W = 4
)(
   input  logic clk,
   input  logic reset,
`ifdef SINGLE_STEP_EN
   input  logic step_en,
`endif
   fetch_sequencer_if.master bus
);

   state_t     r_state;
   state_t     w_next;
   cw_t        w_cw;
   cw_t        w_cw_gated;
   logic [1:0] w_t_step;
   logic [3:0] w_opcode;
   logic       w_advance;
   logic       w_unused_operand;

   assign w_opcode = 4'(bus.instr[7:8-OP_W]);
   // The operand reaches the bus through the IR, not through this block.
   assign w_unused_operand = ^bus.instr[N-1:0];

   seq_decode u_decode (
      .i_state      (r_state),
      .i_opcode     (w_opcode),
      .i_flag_carry (bus.flag_carry),
      .i_flag_zero  (bus.flag_zero),
      .o_cw         (w_cw),
      .o_next       (w_next),
      .o_t_step     (w_t_step)
   );

`ifdef SINGLE_STEP_EN
   assign w_advance  = step_en;
   assign w_cw_gated = step_en ? w_cw : (w_cw & ~CW_WRITE_MASK);
`else
   assign w_advance  = 1'b1;
   assign w_cw_gated = w_cw;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_INIT;
      else if (w_advance)
         r_state <= w_next;
   end

   assign bus.pc_reset = w_cw_gated[CW_PC_RESET];
   assign bus.pc_out   = w_cw_gated[CW_PC_OUT];
   assign bus.pc_count = w_cw_gated[CW_PC_COUNT];
   assign bus.pc_jump  = w_cw_gated[CW_PC_JUMP];
   assign bus.mar_in   = w_cw_gated[CW_MAR_IN];
   assign bus.ram_out  = w_cw_gated[CW_RAM_OUT];
   assign bus.ir_in    = w_cw_gated[CW_IR_IN];
   assign bus.ir_out   = w_cw_gated[CW_IR_OUT];
   assign bus.halted   = w_cw_gated[CW_HALTED];
   assign bus.t_step   = w_t_step;

endmodule
